// File: rtl/basic_computer_pkg.sv
// Shared definitions for the basic computer control path: bus source codes,
// strobe bit indices, opcodes, register-reference bit positions, AC function
// codes and the sequencer state encoding.
package basic_computer_pkg;

  // Bus source select codes
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_AR   = 3'b001;
  localparam logic [2:0] SEL_PC   = 3'b010;
  localparam logic [2:0] SEL_DR   = 3'b011;
  localparam logic [2:0] SEL_AC   = 3'b100;
  localparam logic [2:0] SEL_IR   = 3'b101;
  localparam logic [2:0] SEL_TR   = 3'b110;
  localparam logic [2:0] SEL_MEM  = 3'b111;

  // LD strobe bit indices
  localparam int unsigned LD_AR = 0;
  localparam int unsigned LD_PC = 1;
  localparam int unsigned LD_DR = 2;
  localparam int unsigned LD_AC = 3;
  localparam int unsigned LD_IR = 4;
  localparam int unsigned LD_TR = 5;

  // INR / CLR strobe bit indices
  localparam int unsigned RG_AR = 0;
  localparam int unsigned RG_PC = 1;
  localparam int unsigned RG_DR = 2;
  localparam int unsigned RG_AC = 3;
  localparam int unsigned RG_TR = 4;

  // Opcodes
  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_LDA    = 3'd2;
  localparam logic [2:0] OP_STA    = 3'd3;
  localparam logic [2:0] OP_BUN    = 3'd4;
  localparam logic [2:0] OP_BSA    = 3'd5;
  localparam logic [2:0] OP_ISZ    = 3'd6;
  localparam logic [2:0] OP_REGREF = 3'd7;

  // Register-reference bit positions within ir[11:0]
  localparam logic [3:0] RR_CLA  = 4'd11;
  localparam logic [3:0] RR_CMA  = 4'd9;
  localparam logic [3:0] RR_INC  = 4'd5;
  localparam logic [3:0] RR_SPA  = 4'd4;
  localparam logic [3:0] RR_SNA  = 4'd3;
  localparam logic [3:0] RR_SZA  = 4'd2;
  localparam logic [3:0] RR_HLT  = 4'd0;
  localparam logic [3:0] RR_NONE = 4'd12;

  // AC input function codes
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_DR  = 2'b10;
  localparam logic [1:0] ALU_CMA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Index of the highest set bit, RR_NONE when no bit is set.
  function automatic logic [3:0] rr_msb(input logic [11:0] bits);
    logic [3:0] idx;
    idx = RR_NONE;
    for (int unsigned k = 0; k < 12; k++) begin
      if (bits[k]) idx = 4'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_control_unit_seq_counter.sv
// seq_counter: timing step counter T0..T6 with synchronous clear and
// increment. Any value above 6 is forced back to 0 on the next edge.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   i_clr        : clear to 0 (wins over increment)
//   i_inc        : increment by one
//   o_sc         : current step
//   o_t          : one-hot decode of T0..T6 (all zero for illegal values)
module seq_counter #(
  parameter int unsigned SC_WIDTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_clr,
  input  logic                i_inc,
  output logic [SC_WIDTH-1:0] o_sc,
  output logic [6:0]          o_t
);

  localparam logic [SC_WIDTH-1:0] SC_MAX = SC_WIDTH'(6);

  logic [SC_WIDTH-1:0] r_sc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sc <= '0;
    end else if (i_clr || (r_sc > SC_MAX)) begin
      r_sc <= '0;
    end else if (i_inc) begin
      r_sc <= r_sc + SC_WIDTH'(1);
    end
  end

  always_comb begin
    o_t = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      o_t[k] = (r_sc == SC_WIDTH'(k));
    end
  end

  assign o_sc = r_sc;

endmodule

// File: rtl/bus_control_unit.sv
// bus_control_unit: hardwired control sequencer for the 16-bit basic
// computer. Drives the common bus select, register strobes and memory
// controls through fetch, decode and execute using timing steps T0..T6.
// Build option: SINGLE_STEP_EN -- when defined, each completed instruction
//   returns to IDLE so every start pulse runs exactly one instruction.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   start                  : one-cycle pulse, starts/resumes from IDLE or HALT
//   ir                     : IR contents (I, opcode, address/reg-ref bits)
//   ac_zero/ac_sign/dr_zero: datapath status flags
//   select                 : bus source code
//   LD / INR / CLR         : register load / increment / clear strobes
//   read / write / enable  : memory controls (enable = read | write)
//   alu_op                 : AC input function, meaningful when LD[3]
//   halted                 : high in HALT
//   sc                     : current timing step
module bus_control_unit
  import basic_computer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned SC_WIDTH   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] ir,
  input  logic                  ac_zero,
  input  logic                  ac_sign,
  input  logic                  dr_zero,
  output logic [2:0]            select,
  output logic [5:0]            LD,
  output logic [4:0]            INR,
  output logic [4:0]            CLR,
  output logic                  read,
  output logic                  write,
  output logic                  enable,
  output logic [1:0]            alu_op,
  output logic                  halted,
  output logic [SC_WIDTH-1:0]   sc
);

  state_t              r_state;
  state_t              w_next;
  logic                r_i;
  logic [2:0]          r_op;
  logic [SC_WIDTH-1:0] w_sc;
  logic [6:0]          w_t;
  logic                w_clr;
  logic                w_hlt;
  logic                w_run;
  logic [3:0]          w_rr;

  assign w_run = (r_state == ST_RUN);
  assign w_rr  = rr_msb(ir[11:0]);

  seq_counter #(.SC_WIDTH(SC_WIDTH)) u_seq_counter (
    .clock (clock),
    .reset (reset),
    .i_clr (!w_run || w_clr || w_hlt),
    .i_inc (w_run),
    .o_sc  (w_sc),
    .o_t   (w_t)
  );

  // State register plus the I/opcode latch captured at T2.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_i     <= 1'b0;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (w_run && w_t[2]) begin
        r_i  <= ir[15];
        r_op <= ir[14:12];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_HALT: if (start) w_next = ST_RUN;
      ST_RUN: begin
        if (w_hlt) begin
          w_next = ST_HALT;
        end else if (w_clr) begin
`ifdef SINGLE_STEP_EN
          w_next = ST_IDLE;
`else
          w_next = ST_RUN;
`endif
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    select = SEL_NONE;
    LD     = '0;
    INR    = '0;
    CLR    = '0;
    read   = 1'b0;
    write  = 1'b0;
    alu_op = ALU_AND;
    w_clr  = 1'b0;
    w_hlt  = 1'b0;
    if (w_run) begin
      if (w_t[0]) begin
        select      = SEL_PC;
        LD[LD_AR]   = 1'b1;
      end else if (w_t[1]) begin
        select      = SEL_MEM;
        read        = 1'b1;
        LD[LD_IR]   = 1'b1;
        INR[RG_PC]  = 1'b1;
      end else if (w_t[2]) begin
        select      = SEL_IR;
        LD[LD_AR]   = 1'b1;
      end else if (w_t[3]) begin
        if (r_op == OP_REGREF) begin
          w_clr = 1'b1;
          // Only the highest set bit is decoded; unsupported bits do nothing.
          case (w_rr)
            RR_CLA: CLR[RG_AC] = 1'b1;
            RR_CMA: begin
              LD[LD_AC] = 1'b1;
              alu_op    = ALU_CMA;
            end
            RR_INC: INR[RG_AC] = 1'b1;
            RR_SPA: INR[RG_PC] = !ac_sign;
            RR_SNA: INR[RG_PC] = ac_sign;
            RR_SZA: INR[RG_PC] = ac_zero;
            RR_HLT: w_hlt = 1'b1;
            default: ;
          endcase
        end else if (r_i) begin
          select    = SEL_MEM;
          read      = 1'b1;
          LD[LD_AR] = 1'b1;
        end
      end else if (w_t[4]) begin
        case (r_op)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            select    = SEL_MEM;
            read      = 1'b1;
            LD[LD_DR] = 1'b1;
          end
          OP_STA: begin
            select = SEL_AC;
            write  = 1'b1;
            w_clr  = 1'b1;
          end
          OP_BUN: begin
            select    = SEL_AR;
            LD[LD_PC] = 1'b1;
            w_clr     = 1'b1;
          end
          OP_BSA: begin
            select     = SEL_PC;
            write      = 1'b1;
            INR[RG_AR] = 1'b1;
          end
          default: w_clr = 1'b1;
        endcase
      end else if (w_t[5]) begin
        case (r_op)
          OP_AND, OP_ADD, OP_LDA: begin
            LD[LD_AC] = 1'b1;
            w_clr     = 1'b1;
            case (r_op)
              OP_AND:  alu_op = ALU_AND;
              OP_ADD:  alu_op = ALU_ADD;
              default: alu_op = ALU_DR;
            endcase
          end
          OP_BSA: begin
            select    = SEL_AR;
            LD[LD_PC] = 1'b1;
            w_clr     = 1'b1;
          end
          OP_ISZ:  INR[RG_DR] = 1'b1;
          default: w_clr = 1'b1;
        endcase
      end else if (w_t[6]) begin
        w_clr = 1'b1;
        if (r_op == OP_ISZ) begin
          select     = SEL_DR;
          write      = 1'b1;
          INR[RG_PC] = dr_zero;
        end
      end
    end
  end

  assign enable = read | write;
  assign halted = (r_state == ST_HALT);
  assign sc     = w_sc;

endmodule

// File: tb/tb_bus_control_unit.sv
// Directed bench for bus_control_unit: expected per-cycle control vectors
// are queued as each instruction is issued and compared cycle by cycle.
module tb_bus_control_unit;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [15:0] ir      = '0;
  logic        ac_zero = 1'b0;
  logic        ac_sign = 1'b0;
  logic        dr_zero = 1'b0;

  logic [2:0] select;
  logic [5:0] LD;
  logic [4:0] INR;
  logic [4:0] CLR;
  logic       read, write, enable, halted;
  logic [1:0] alu_op;
  logic [2:0] sc;

  bus_control_unit #(.WORD_WIDTH(16), .SC_WIDTH(3)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .ir      (ir),
    .ac_zero (ac_zero),
    .ac_sign (ac_sign),
    .dr_zero (dr_zero),
    .select  (select),
    .LD      (LD),
    .INR     (INR),
    .CLR     (CLR),
    .read    (read),
    .write   (write),
    .enable  (enable),
    .alu_op  (alu_op),
    .halted  (halted),
    .sc      (sc)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [27:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [27:0] obs;
  assign obs = {select, LD, INR, CLR, read, write, enable, alu_op, halted, sc};

  function automatic logic [27:0] mk(input logic [2:0] sel, input logic [5:0] ld,
                                     input logic [4:0] inr, input logic [4:0] clr,
                                     input logic rd, input logic wr,
                                     input logic [1:0] alu, input logic h,
                                     input logic [2:0] s);
    return {sel, ld, inr, clr, rd, wr, rd | wr, alu, h, s};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string tag, input logic [27:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      check_next();
      tick();
    end
  endtask

  task automatic push_fetch(input string t);
    push({t, "_T0"}, mk(3'b010, 6'b000001, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0));
    push({t, "_T1"}, mk(3'b111, 6'b010000, 5'b00010, 5'b00000, 1'b1, 1'b0, 2'b00, 1'b0, 3'd1));
    push({t, "_T2"}, mk(3'b101, 6'b000001, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd2));
  endtask

  task automatic push_idle(input string t, input logic h, input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      push(t, mk(3'b000, 6'b000000, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'b00, h, 3'd0));
  endtask

  initial begin
    // Reset held for two cycles, then idle with no start
    tick();
    tick();
    reset = 1'b0;
    push_idle("reset_idle", 1'b0, 5);
    drain();

    // LDA direct
    ir = 16'h2010;
    start = 1'b1;
    tick();
    start = 1'b0;
    push_fetch("lda");
    push("lda_T3", mk(3'b000, 6'b000000, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd3));
    push("lda_T4", mk(3'b111, 6'b000100, 5'b00000, 5'b00000, 1'b1, 1'b0, 2'b00, 1'b0, 3'd4));
    push("lda_T5", mk(3'b000, 6'b001000, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'b10, 1'b0, 3'd5));
    drain();

    // STA indirect
    ir = 16'hB020;
    push_fetch("sta");
    push("sta_T3", mk(3'b111, 6'b000001, 5'b00000, 5'b00000, 1'b1, 1'b0, 2'b00, 1'b0, 3'd3));
    push("sta_T4", mk(3'b100, 6'b000000, 5'b00000, 5'b00000, 1'b0, 1'b1, 2'b00, 1'b0, 3'd4));
    drain();

    // ISZ with DR reaching zero
    ir = 16'h6030;
    dr_zero = 1'b1;
    push_fetch("isz");
    push("isz_T3", mk(3'b000, 6'b000000, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd3));
    push("isz_T4", mk(3'b111, 6'b000100, 5'b00000, 5'b00000, 1'b1, 1'b0, 2'b00, 1'b0, 3'd4));
    push("isz_T5", mk(3'b000, 6'b000000, 5'b00100, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd5));
    push("isz_T6", mk(3'b011, 6'b000000, 5'b00010, 5'b00000, 1'b0, 1'b1, 2'b00, 1'b0, 3'd6));
    drain();
    dr_zero = 1'b0;

    // SZA with AC zero: skip
    ir = 16'h7004;
    ac_zero = 1'b1;
    push_fetch("sza1");
    push("sza1_T3", mk(3'b000, 6'b000000, 5'b00010, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd3));
    drain();

    // SZA with AC nonzero: no strobes
    ac_zero = 1'b0;
    push_fetch("sza0");
    push("sza0_T3", mk(3'b000, 6'b000000, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd3));
    drain();

    // HLT
    ir = 16'h7001;
    push_fetch("hlt");
    push("hlt_T3", mk(3'b000, 6'b000000, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd3));
    push_idle("halted", 1'b1, 3);
    drain();

    // Resume from HALT with LDA, reset during T4
    ir = 16'h2010;
    start = 1'b1;
    tick();
    start = 1'b0;
    push_fetch("lda_r");
    push("lda_r_T3", mk(3'b000, 6'b000000, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'b00, 1'b0, 3'd3));
    push("lda_r_T4", mk(3'b111, 6'b000100, 5'b00000, 5'b00000, 1'b1, 1'b0, 2'b00, 1'b0, 3'd4));
    repeat (4) begin
      check_next();
      tick();
    end
    check_next();
    reset = 1'b1;
    tick();
    push_idle("abort_reset", 1'b0, 1);
    check_next();
    reset = 1'b0;
    tick();
    push_idle("abort_idle", 1'b0, 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
